data_mem_mmio: RTL and testbench

Data-side memory and memory-mapped I/O block directly downstream of the single-cycle processor. It consumes `WE`, `address_to_mem` and `data_to_mem`, and returns `data_from_mem` combinationally in the same cycle. It holds a word RAM, a free-running cycle counter, a compare timer with interrupt flag, and a byte output FIFO drained by a valid/ready consumer.

---
 rtl/data_mem_mmio.sv | 143 ++++++++++++++
 tb/tb_data_mem_mmio.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// Data-side memory for the single-cycle core: word RAM plus memory-mapped cycle
// counter, compare timer with interrupt flag, and a byte output FIFO.
module data_mem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_CMP    = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] ADDR_TX     = 32'hFFFF_000C;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycle_q;
  logic [31:0]   timer_cmp_q;
  logic          flag_q;
  logic          overflow_q;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  logic [31:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic          ram_hit;
  logic          hit_cycle;
  logic          hit_cmp;
  logic          hit_status;
  logic          hit_tx;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push_req;
  logic          push;
  logic [31:0]   status_word;

  // Bits [1:0] are ignored everywhere: every access is a full word.
  assign word_addr  = {address_to_mem[31:2], 2'b00};
  assign ram_idx    = address_to_mem[AW+1:2];
  assign ram_hit    = (address_to_mem[31:AW+2] == '0);
  assign hit_cycle  = (word_addr == ADDR_CYCLE);
  assign hit_cmp    = (word_addr == ADDR_CMP);
  assign hit_status = (word_addr == ADDR_STATUS);
  assign hit_tx     = (word_addr == ADDR_TX);

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && out_ready;
  assign push_req   = WE && hit_tx;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push       = push_req && (!fifo_full || pop);

  assign status_word = {23'b0, 5'(count_q), overflow_q, fifo_empty, fifo_full, flag_q};

  assign out_data  = fifo_mem[rd_ptr_q];
  assign out_valid = !fifo_empty;
  assign irq       = flag_q;

  always_comb begin
    data_from_mem = '0;
    if (ram_hit) begin
      data_from_mem = ram[ram_idx];
    end else if (hit_cycle) begin
      data_from_mem = cycle_q;
    end else if (hit_cmp) begin
      data_from_mem = timer_cmp_q;
    end else if (hit_status) begin
      data_from_mem = status_word;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (WE && ram_hit) begin
      ram[ram_idx] <= data_to_mem;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q     <= '0;
      timer_cmp_q <= 32'hFFFF_FFFF;
      flag_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (WE && hit_cmp) begin
        timer_cmp_q <= data_to_mem;
      end
      // Compare match takes priority over a same-edge W1C clear.
      if (cycle_q == timer_cmp_q) begin
        flag_q <= 1'b1;
      end else if (WE && hit_status && data_to_mem[0]) begin
        flag_q <= 1'b0;
      end
      if (push_req && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end else if (WE && hit_status && data_to_mem[3]) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= data_to_mem[7:0];
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed and randomized bench for data_mem_mmio against a queue/array based
// model of the memory map, timer and output FIFO.
module tb_data_mem_mmio;

  localparam int RW = 64;
  localparam int FD = 4;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] A_CMP    = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_TX     = 32'hFFFF_000C;

  logic        clk;
  logic        reset;
  logic        WE;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_ram [RW];
  bit          m_written [RW];
  logic [31:0] m_cycle;
  logic [31:0] m_cmp;
  bit          m_flag;
  bit          m_ov;
  logic [7:0]  exp_q [$];

  data_mem_mmio #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk            (clk),
    .reset          (reset),
    .WE             (WE),
    .address_to_mem (address_to_mem),
    .data_to_mem    (data_to_mem),
    .data_from_mem  (data_from_mem),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .irq            (irq)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cycle = '0;
    m_cmp   = 32'hFFFF_FFFF;
    m_flag  = 1'b0;
    m_ov    = 1'b0;
    exp_q.delete();
  endtask

  function automatic bit exp_read(input logic [31:0] a, output logic [31:0] v);
    logic [31:0] wa;
    int          idx;
    wa  = {a[31:2], 2'b00};
    v   = '0;
    idx = int'(wa >> 2);
    if (wa < RW * 4) begin
      v = m_ram[idx];
      return m_written[idx];
    end
    if (wa == A_CYCLE) v = m_cycle;
    else if (wa == A_CMP) v = m_cmp;
    else if (wa == A_STATUS)
      v = {23'b0, 5'(exp_q.size()), m_ov, exp_q.size() == 0, exp_q.size() == FD, m_flag};
    return 1'b1;
  endfunction

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    WE             = we;
    address_to_mem = a;
    data_to_mem    = d;
    out_ready      = rdy;
  endtask

  task automatic check_read(input string tag);
    logic [31:0] v;
    #1;
    if (exp_read(address_to_mem, v)) chk(tag, data_from_mem, v);
  endtask

  // Advance the model across one edge from the currently driven inputs.
  task automatic tick();
    logic [31:0] wa;
    bit          pop;
    bit          full;
    bit          wr_status;
    bit          wr_tx;
    wa        = {address_to_mem[31:2], 2'b00};
    pop       = (exp_q.size() != 0) && out_ready;
    full      = (exp_q.size() == FD);
    wr_status = WE && (wa == A_STATUS);
    wr_tx     = WE && (wa == A_TX);
    if (m_cycle == m_cmp) m_flag = 1'b1;
    else if (wr_status && data_to_mem[0]) m_flag = 1'b0;
    if (wr_tx && full && !pop) m_ov = 1'b1;
    else if (wr_status && data_to_mem[3]) m_ov = 1'b0;
    if (WE && wa < RW * 4) begin
      m_ram[int'(wa >> 2)]     = data_to_mem;
      m_written[int'(wa >> 2)] = 1'b1;
    end
    if (WE && wa == A_CMP) m_cmp = data_to_mem;
    if (pop) void'(exp_q.pop_front());
    if (wr_tx && (!full || pop)) exp_q.push_back(data_to_mem[7:0]);
    m_cycle = m_cycle + 32'd1;
    @(posedge clk);
    #1;
    chk("irq", {31'b0, irq}, {31'b0, m_flag});
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("out_data", {24'b0, out_data}, {24'b0, exp_q[0]});
  endtask

  task automatic step(input string tag);
    check_read(tag);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          sel;
    for (int i = 0; i < RW; i++) m_written[i] = 1'b0;
    model_reset();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;

    // Reset state
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_out_data", {24'b0, out_data}, 32'h0);
    drive(1'b0, A_STATUS, 32'h0, 1'b0);
    #1 chk("rst_status", data_from_mem, 32'h4);
    drive(1'b0, A_CMP, 32'h0, 1'b0);
    #1 chk("rst_cmp", data_from_mem, 32'hFFFF_FFFF);
    drive(1'b0, A_CYCLE, 32'h0, 1'b0);
    #1 chk("rst_cycle", data_from_mem, 32'h0);
    for (int i = 0; i < 3; i++) step("cycle_adv");
    check_read("cycle_after3");

    // Timer: CMP=20 written at cycle 5
    for (int i = 0; i < 10 && m_cycle < 5; i++) step("idle");
    drive(1'b1, A_CMP, 32'd20, 1'b0);
    step("cmp_write");
    drive(1'b0, A_CYCLE, 32'h0, 1'b0);
    for (int i = 0; i < 40 && m_cycle < 21; i++) step("wait_irq");
    chk("irq_set", {31'b0, irq}, 32'h1);
    drive(1'b1, A_STATUS, 32'h1, 1'b0);
    step("w1c");
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    drive(1'b1, A_CMP, m_cycle + 32'd3, 1'b0);
    step("cmp_write2");
    drive(1'b0, A_CYCLE, 32'h0, 1'b0);
    for (int i = 0; i < 10 && m_cycle != m_cmp; i++) step("wait_match");
    drive(1'b1, A_STATUS, 32'h1, 1'b0);
    step("set_vs_clear");
    chk("set_wins", {31'b0, irq}, 32'h1);

    // RAM
    drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    step("ram_store");
    drive(1'b0, 32'h10, 32'h0, 1'b0);
    #1 chk("ram_0x10", data_from_mem, 32'hDEAD_BEEF);
    drive(1'b0, 32'h13, 32'h0, 1'b0);
    #1 chk("ram_0x13", data_from_mem, 32'hDEAD_BEEF);
    drive(1'b0, 32'h2000, 32'h0, 1'b0);
    #1 chk("unmapped_0x2000", data_from_mem, 32'h0);
    drive(1'b0, A_TX, 32'h0, 1'b0);
    #1 chk("tx_read", data_from_mem, 32'h0);

    // FIFO overflow and same-edge push/pop when full
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, A_TX, 32'h41 + i, 1'b0);
      step("push");
    end
    drive(1'b0, A_STATUS, 32'h0, 1'b0);
    #1;
    chk("fifo_count4", {27'b0, data_from_mem[8:4]}, 32'd4);
    chk("fifo_ovf", {31'b0, data_from_mem[3]}, 32'h1);
    chk("fifo_full", {31'b0, data_from_mem[1]}, 32'h1);
    drive(1'b1, A_TX, 32'h55, 1'b1);
    step("push_pop_full");
    drive(1'b0, A_STATUS, 32'h0, 1'b0);
    #1;
    chk("fifo_count_still4", {27'b0, data_from_mem[8:4]}, 32'd4);
    chk("ovf_unchanged", {31'b0, data_from_mem[3]}, 32'h1);
    chk("head_after_pop", {24'b0, out_data}, 32'h42);
    drive(1'b0, A_STATUS, 32'h0, 1'b1);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step("drain");
    chk("drained", {31'b0, out_valid}, 32'h0);
    drive(1'b1, A_STATUS, 32'h8, 1'b0);
    step("clear_ovf");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 7);
      d   = $urandom;
      case (sel)
        0, 1: a = ($urandom_range(8, RW - 1) * 4) + $urandom_range(0, 3);
        2:    a = A_CYCLE;
        3:    begin a = A_CMP; d = m_cycle + $urandom_range(1, 15); end
        4:    a = A_STATUS;
        6:    a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_0010 : (RW * 4 + $urandom_range(0, 255) * 4);
        default: a = A_TX;
      endcase
      drive(1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)));
      step("rand");
    end

    // Reset in the middle of a drain
    drive(1'b0, A_STATUS, 32'h0, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step("pre_drain");
    drive(1'b1, A_CMP, m_cycle + 32'd2, 1'b0);
    step("cmp_for_reset");
    drive(1'b0, A_STATUS, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step("idle2");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, A_TX, 32'h60 + i, 1'b0);
      step("push_pre_rst");
    end
    drive(1'b0, A_STATUS, 32'h0, 1'b1);
    step("pop_one");
    chk("two_entries", 32'(exp_q.size()), 32'd2);
    chk("irq_before_rst", {31'b0, irq}, 32'h1);
    drive(1'b0, A_CYCLE, 32'h0, 1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    chk("mid_rst_cycle", data_from_mem, 32'h0);
    chk("mid_rst_out_data", {24'b0, out_data}, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    drive(1'b0, 32'h10, 32'h0, 1'b0);
    #1 chk("ram_kept", data_from_mem, 32'hDEAD_BEEF);
    drive(1'b0, A_STATUS, 32'h0, 1'b0);
    #1 chk("status_after_rst", data_from_mem, 32'h4);
    for (int i = 0; i < 4; i++) step("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
